// File: rtl/wb_select_pipe.sv
// rtl/wb_select_pipe.sv - write-back source selector with valid/ready output stage and 1-entry skid buffer
// Optional build macro: WB_FLAGS_EN adds out_zero/out_neg flag outputs carried with each word.
module wb_select_pipe #(
    parameter int BITS    = 8,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_SRC*BITS-1:0] src_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BITS-1:0]         out_data,
    output logic                    sel_err,
`ifdef WB_FLAGS_EN
    output logic                    out_zero,
    output logic                    out_neg,
`endif
    output logic [CNT_W-1:0]        xfer_cnt
);

`ifdef WB_FLAGS_EN
    localparam int PW = BITS + 2;
`else
    localparam int PW = BITS;
`endif

    // Compare one bit wider than sel so a power-of-two NUM_SRC never reports a bad select.
    localparam logic [SEL_W:0] SRC_LIMIT = (SEL_W+1)'(NUM_SRC);

    logic [BITS-1:0] word;
    logic            sel_bad;
    logic [PW-1:0]   word_p;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic            skid_valid;
    logic            out_valid_q;
    logic            sel_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic            accept;
    logic            drain;

    always_comb begin
        word    = '0;
        sel_bad = ({1'b0, sel} >= SRC_LIMIT);
        for (int k = 0; k < NUM_SRC; k++) begin
            if ({1'b0, sel} == (SEL_W+1)'(k)) begin
                word = src_data[k*BITS +: BITS];
            end
        end
    end

`ifdef WB_FLAGS_EN
    assign word_p = {word[BITS-1], (word == '0), word};
`else
    assign word_p = word;
`endif

    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q      <= '0;
            skid_q      <= '0;
            skid_valid  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept && (!out_valid_q || out_ready)) begin
            main_q      <= word_p;
            out_valid_q <= 1'b1;
        end else if (accept) begin
            // Consumer is stalled: park the new word, main stays stable.
            skid_q      <= word_p;
            skid_valid  <= 1'b1;
        end else if (drain && skid_valid) begin
            main_q      <= skid_q;
            skid_valid  <= 1'b0;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sel_err_q <= accept & sel_bad;
            if (drain) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q[BITS-1:0];
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = cnt_q;

`ifdef WB_FLAGS_EN
    assign out_zero = main_q[BITS];
    assign out_neg  = main_q[BITS+1];
`endif

endmodule

// File: tb/tb_wb_select_pipe.sv
// tb/tb_wb_select_pipe.sv - self-checking scoreboard bench for wb_select_pipe
module tb_wb_select_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [23:0] src_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        sel_err;
    logic [7:0]  xfer_cnt;
`ifdef WB_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif

    int tests_run;
    int tests_failed;
    logic [7:0] exp_q[$];

    wb_select_pipe #(.BITS(8), .NUM_SRC(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .src_data  (src_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
`ifdef WB_FLAGS_EN
        .out_zero  (out_zero),
        .out_neg   (out_neg),
`endif
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] model_word(input logic [1:0] s, input logic [23:0] d);
        case (s)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return 8'h00;
        endcase
    endfunction

    // One clock cycle; handshakes are observed mid-cycle where inputs and outputs are settled.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_extra: out_data=%h drained, required no output (scoreboard empty)", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    tests_failed++;
                    $display("FAIL sb_order: out_data=%h, required %h", out_data, e);
                end
            end
        end
        if (rst_n && in_valid && in_ready) exp_q.push_back(model_word(sel, src_data));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || sel_err !== 1'b0 || xfer_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_values: ov=%b ir=%b od=%h se=%b cnt=%0d, required 0 1 00 0 0",
                     out_valid, in_ready, out_data, sel_err, xfer_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // one completed transfer so the counter is non-zero, then fill main and skid
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0; src_data = 24'h11_22_33;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        tick();
        sel = 2'd2;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_midstream: ov=%b ir=%b cnt=%0d, required 0 1 0", out_valid, in_ready, xfer_cnt);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_select();
        out_ready = 1'b1;
        src_data  = {8'h5A, 8'h33, 8'hCC};
        in_valid  = 1'b1; sel = 2'd1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h33) begin
            tests_failed++;
            $display("FAIL basic_sel1: ov=%b od=%h, required 1 33", out_valid, out_data);
        end
        sel = 2'd0;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hCC) begin
            tests_failed++;
            $display("FAIL basic_sel0: ov=%b od=%h, required 1 cc", out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'hCC) begin
            tests_failed++;
            $display("FAIL basic_idle: ov=%b od=%h, required 0 cc (hold)", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        src_data  = {8'h00, 8'hE6, 8'hF1};
        in_valid  = 1'b1; sel = 2'd1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_data !== 8'hE6) begin
            tests_failed++;
            $display("FAIL bp_first: ir=%b od=%h, required 1 e6", in_ready, out_data);
        end
        sel = 2'd0;
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 8'hE6) begin
            tests_failed++;
            $display("FAIL bp_full: ir=%b od=%h, required 0 e6", in_ready, out_data);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hE6) begin
            tests_failed++;
            $display("FAIL bp_stable: ov=%b od=%h, required 1 e6", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hF1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_skid: ov=%b od=%h ir=%b, required 1 f1 1", out_valid, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: ov=%b, required 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            sel      = 2'(i % 3);
            src_data = 24'($urandom);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_bubble[%0d]: ov=%b ir=%b, required 1 1", i, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (xfer_cnt !== 8'd10 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stream_count: cnt=%0d pending=%0d, required 10 0", xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_bad_select();
        out_ready = 1'b1;
        src_data  = 24'hA5_C3_7E;
        in_valid  = 1'b1; sel = 2'd3;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || sel_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL badsel_word: ov=%b od=%h se=%b, required 1 00 1", out_valid, out_data, sel_err);
        end
        sel = 2'd2;
        tick();
        tests_run++;
        if (sel_err !== 1'b0 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL badsel_pulse: se=%b od=%h, required 0 a5", sel_err, out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            sel      = 2'($urandom_range(0, 2));
            src_data = 24'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (xfer_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL cnt_wrap: cnt=%0d, required 1", xfer_cnt);
        end
    endtask

`ifdef WB_FLAGS_EN
    task automatic test_flags();
        out_ready = 1'b1;
        in_valid  = 1'b1; sel = 2'd0; src_data = 24'h00_00_00;
        tick();
        tests_run++;
        if (out_zero !== 1'b1 || out_neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL flags_zero: z=%b n=%b, required 1 0", out_zero, out_neg);
        end
        src_data = 24'h00_00_AA;
        tick();
        tests_run++;
        if (out_zero !== 1'b0 || out_neg !== 1'b1) begin
            tests_failed++;
            $display("FAIL flags_neg: z=%b n=%b, required 0 1", out_zero, out_neg);
        end
        in_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random_traffic();
        logic       hold;
        logic [7:0] held;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel       = 2'($urandom_range(0, 3));
            src_data  = 24'($urandom);
            hold = out_valid && !out_ready;
            held = out_data;
            tick();
            if (hold) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    tests_failed++;
                    $display("FAIL rand_stable[%0d]: ov=%b od=%h, required 1 %h", i, out_valid, out_data, held);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        tests_run++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_drain: pending=%0d ov=%b, required 0 0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        sel          = 2'd0;
        src_data     = 24'h0;
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_select();
        test_backpressure();
        test_streaming();
        test_bad_select();
        test_counter_wrap();
`ifdef WB_FLAGS_EN
        test_flags();
`endif
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
